// File: rtl/memory_if.sv
// Dual-view state memory bus: a 25-bit slice port and a 64-bit lane port.
// The master drives addresses, data and enables. The slave returns the read data.
interface memory_if;
    logic        mode;
    logic [5:0]  adr25;
    logic [0:24] in25;
    logic        r25;
    logic        w25;
    logic [0:24] out25;
    logic [4:0]  adr64;
    logic [0:63] in64;
    logic        r64;
    logic        w64;
    logic [0:63] out64;

    modport master (
        output mode, adr25, in25, r25, w25, adr64, in64, r64, w64,
        input  out25, out64
    );

    modport slave (
        input  mode, adr25, in25, r25, w25, adr64, in64, r64, w64,
        output out25, out64
    );
endinterface

// File: rtl/memory.sv
// 1600-bit state (25 lanes x 64 bits) with a lane view and a slice view.
// Writes are clocked. Reads are combinational and return zero unless enabled.
module memory (
    input  logic     clk,
    input  logic     rst,
    memory_if.slave  bus
);

    logic [0:24][0:63] st;
    logic              lane_ok;
    logic [0:24]       slice_rd;
    logic [0:63]       lane_rd;

    // Lane addresses 25..31 do not exist: writes are dropped and reads return zero.
    assign lane_ok = (bus.adr64 < 5'd25);

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
        end else if (bus.mode) begin
            if (bus.w25) begin
                for (int i = 0; i < 25; i++) begin
                    st[i][bus.adr25] <= bus.in25[i];
                end
            end
        end else if (bus.w64 && lane_ok) begin
            st[bus.adr64] <= bus.in64;
        end
    end

    always_comb begin
        slice_rd = '0;
        if (bus.mode && bus.r25) begin
            for (int i = 0; i < 25; i++) begin
                slice_rd[i] = st[i][bus.adr25];
            end
        end
    end

    always_comb begin
        lane_rd = '0;
        if (!bus.mode && bus.r64 && lane_ok) begin
            lane_rd = st[bus.adr64];
        end
    end

    assign bus.out25 = slice_rd;
    assign bus.out64 = lane_rd;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the dual-view state memory.
// It compares directed scenarios and random traffic against an array model.
module tb_memory;

    logic clk;
    logic rst;
    memory_if bus ();

    memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [0:63] m [25];

    function automatic logic [0:63] exp_lane(input int l);
        if (l > 24) return '0;
        return m[l];
    endfunction

    function automatic logic [0:24] exp_slice(input int z);
        logic [0:24] r;
        for (int i = 0; i < 25; i++) r[i] = m[i][z];
        return r;
    endfunction

    function automatic void model_clear();
        for (int l = 0; l < 25; l++) m[l] = '0;
    endfunction

    function automatic void model_lane_write(input int l, input logic [0:63] d);
        if (l < 25) m[l] = d;
    endfunction

    function automatic void model_slice_write(input int z, input logic [0:24] d);
        for (int i = 0; i < 25; i++) m[i][z] = d[i];
    endfunction

    task automatic idle();
        rst       = 1'b0;
        bus.mode  = 1'b0;
        bus.adr25 = '0;
        bus.in25  = '0;
        bus.r25   = 1'b0;
        bus.w25   = 1'b0;
        bus.adr64 = '0;
        bus.in64  = '0;
        bus.r64   = 1'b0;
        bus.w64   = 1'b0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        edge_step();
        model_clear();
        idle();
        bus.mode = 1'b0; bus.r64 = 1'b1; bus.adr64 = 5'd7;
        #1;
        total_cnt++;
        if (bus.out64 !== 64'd0) $display("FAIL reset_lane7 got %h exp 0", bus.out64);
        else pass_cnt++;
        idle();
        bus.mode = 1'b1; bus.r25 = 1'b1; bus.adr25 = 6'd40;
        #1;
        total_cnt++;
        if (bus.out25 !== 25'd0) $display("FAIL reset_slice40 got %h exp 0", bus.out25);
        else pass_cnt++;
        idle();
        #1;
        total_cnt++;
        if (bus.out64 !== 64'd0 || bus.out25 !== 25'd0)
            $display("FAIL idle_outputs got %h/%h exp 0/0", bus.out64, bus.out25);
        else pass_cnt++;
    endtask

    task automatic test_cross_view();
        logic [0:24] sd;
        logic [0:63] ld;
        logic [0:63] lane5;
        sd = 25'b00000_11101_00000_00000_00000;
        ld = {{56{1'b1}}, 8'b0101_0101};
        lane5 = 64'h1000_0000_0000_0000;
        idle();
        bus.mode = 1'b1; bus.w25 = 1'b1; bus.adr25 = 6'd3; bus.in25 = sd;
        edge_step();
        model_slice_write(3, sd);
        idle();
        bus.mode = 1'b0; bus.w64 = 1'b1; bus.adr64 = 5'd3; bus.in64 = ld;
        edge_step();
        model_lane_write(3, ld);
        idle();
        bus.mode = 1'b0; bus.r64 = 1'b1; bus.adr64 = 5'd3;
        #1;
        total_cnt++;
        if (bus.out64 !== ld) $display("FAIL lane3_readback got %h exp %h", bus.out64, ld);
        else pass_cnt++;
        bus.adr64 = 5'd5;
        #1;
        total_cnt++;
        if (bus.out64 !== lane5) $display("FAIL lane5_cross got %h exp %h", bus.out64, lane5);
        else pass_cnt++;
        idle();
        bus.mode = 1'b1; bus.r25 = 1'b1; bus.adr25 = 6'd3;
        #1;
        total_cnt++;
        if (bus.out25 !== exp_slice(3))
            $display("FAIL slice3_cross got %h exp %h", bus.out25, exp_slice(3));
        else pass_cnt++;
    endtask

    task automatic test_mode_gating();
        idle();
        bus.mode = 1'b0; bus.w25 = 1'b1; bus.adr25 = 6'd0; bus.in25 = '1;
        edge_step();
        idle();
        bus.mode = 1'b1; bus.r25 = 1'b1; bus.adr25 = 6'd0;
        #1;
        total_cnt++;
        if (bus.out25 !== exp_slice(0))
            $display("FAIL gated_slice_write got %h exp %h", bus.out25, exp_slice(0));
        else pass_cnt++;
        bus.r64 = 1'b1; bus.adr64 = 5'd3;
        #1;
        total_cnt++;
        if (bus.out64 !== 64'd0) $display("FAIL gated_lane_read got %h exp 0", bus.out64);
        else pass_cnt++;
        idle();
        bus.mode = 1'b1; bus.w64 = 1'b1; bus.adr64 = 5'd4; bus.in64 = '1;
        edge_step();
        idle();
        bus.r64 = 1'b1; bus.adr64 = 5'd4;
        #1;
        total_cnt++;
        if (bus.out64 !== exp_lane(4))
            $display("FAIL gated_lane_write got %h exp %h", bus.out64, exp_lane(4));
        else pass_cnt++;
        bus.r25 = 1'b1;
        #1;
        total_cnt++;
        if (bus.out25 !== 25'd0) $display("FAIL gated_slice_read got %h exp 0", bus.out25);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        int bad;
        idle();
        bus.mode = 1'b0; bus.w64 = 1'b1; bus.adr64 = 5'd27; bus.in64 = '1;
        edge_step();
        idle();
        bus.r64 = 1'b1;
        bad = 0;
        for (int l = 0; l < 25; l++) begin
            bus.adr64 = 5'(l);
            #1;
            if (bus.out64 !== exp_lane(l)) begin
                $display("FAIL oor_lane%0d got %h exp %h", l, bus.out64, exp_lane(l));
                bad++;
            end
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        for (int a = 25; a < 32; a++) begin
            bus.adr64 = 5'(a);
            #1;
            total_cnt++;
            if (bus.out64 !== 64'd0) $display("FAIL oor_read%0d got %h exp 0", a, bus.out64);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_over_write();
        idle();
        rst = 1'b1; bus.mode = 1'b0; bus.w64 = 1'b1; bus.adr64 = 5'd2; bus.in64 = '1;
        edge_step();
        model_clear();
        idle();
        bus.r64 = 1'b1; bus.adr64 = 5'd2;
        #1;
        total_cnt++;
        if (bus.out64 !== 64'd0) $display("FAIL reset_over_write got %h exp 0", bus.out64);
        else pass_cnt++;
        bus.adr64 = 5'd3;
        #1;
        total_cnt++;
        if (bus.out64 !== 64'd0) $display("FAIL reset_clears_lane3 got %h exp 0", bus.out64);
        else pass_cnt++;
    endtask

    task automatic test_read_during_write();
        logic [0:63] d;
        logic [0:24] s;
        logic [0:63] old_l;
        logic [0:24] old_s;
        d = {$urandom, $urandom};
        old_l = exp_lane(10);
        idle();
        bus.mode = 1'b0; bus.r64 = 1'b1; bus.w64 = 1'b1; bus.adr64 = 5'd10; bus.in64 = d;
        #1;
        total_cnt++;
        if (bus.out64 !== old_l) $display("FAIL rdw_lane_pre got %h exp %h", bus.out64, old_l);
        else pass_cnt++;
        edge_step();
        model_lane_write(10, d);
        bus.w64 = 1'b0;
        #1;
        total_cnt++;
        if (bus.out64 !== exp_lane(10))
            $display("FAIL rdw_lane_post got %h exp %h", bus.out64, exp_lane(10));
        else pass_cnt++;
        s = 25'($urandom);
        old_s = exp_slice(63);
        idle();
        bus.mode = 1'b1; bus.r25 = 1'b1; bus.w25 = 1'b1; bus.adr25 = 6'd63; bus.in25 = s;
        #1;
        total_cnt++;
        if (bus.out25 !== old_s) $display("FAIL rdw_slice_pre got %h exp %h", bus.out25, old_s);
        else pass_cnt++;
        edge_step();
        model_slice_write(63, s);
        bus.w25 = 1'b0;
        #1;
        total_cnt++;
        if (bus.out25 !== exp_slice(63))
            $display("FAIL rdw_slice_post got %h exp %h", bus.out25, exp_slice(63));
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [0:63] e64;
        logic [0:24] e25;
        int bad;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            bus.mode  = 1'($urandom);
            bus.adr25 = 6'($urandom);
            bus.in25  = 25'($urandom);
            bus.r25   = 1'($urandom);
            bus.w25   = 1'($urandom);
            bus.adr64 = 5'($urandom);
            bus.in64  = {$urandom, $urandom};
            bus.r64   = 1'($urandom);
            bus.w64   = 1'($urandom);
            e25 = (bus.mode && bus.r25) ? exp_slice(int'(bus.adr25)) : 25'd0;
            e64 = (!bus.mode && bus.r64) ? exp_lane(int'(bus.adr64)) : 64'd0;
            #1;
            if (bus.out25 !== e25 || bus.out64 !== e64) begin
                $display("FAIL random_%0d got %h/%h exp %h/%h", n, bus.out25, bus.out64, e25, e64);
                bad++;
            end
            edge_step();
            if (rst) model_clear();
            else if (bus.mode && bus.w25) model_slice_write(int'(bus.adr25), bus.in25);
            else if (!bus.mode && bus.w64) model_lane_write(int'(bus.adr64), bus.in64);
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        idle();
        bus.r64 = 1'b1;
        bad = 0;
        for (int l = 0; l < 25; l++) begin
            bus.adr64 = 5'(l);
            #1;
            if (bus.out64 !== exp_lane(l)) begin
                $display("FAIL random_final_lane%0d got %h exp %h", l, bus.out64, exp_lane(l));
                bad++;
            end
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
    endtask

    initial begin
        idle();
        #2;
        test_reset();
        test_cross_view();
        test_mode_gating();
        test_out_of_range();
        test_reset_over_write();
        test_read_during_write();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
